lcd_refresh_scheduler: RTL and testbench

Owns the 80-byte character frame buffer feeding the HD44780 4-bit driver and decides when the driver prints. Host logic writes characters through a valid/ready port. The scheduler tracks a dirty flag and issues a one-cycle `lcd_trg` to the driver when the frame changed, the driver is idle and a minimum refresh interval has elapsed. It sits between the host and the driver, and also serves the driver's `idataaddr`/`idata` read port.

---
 rtl/lcd_refresh_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_lcd_refresh_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_scheduler.sv
// Character frame buffer for the HD44780 4-bit driver, plus the scheduler that
// decides when the driver prints the frame.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | waiting for a dirty frame while the driver is idle
// S_TRIG      | lcd_trg high for exactly one cycle
// S_WAIT_BUSY | waiting for the driver to raise lcd_busy, with a timeout
// S_WAIT_DONE | driver printing; the print is counted when busy falls
// S_HOLDOFF   | minimum idle gap before the next print may start
module lcd_refresh_scheduler #(
    parameter int                DEPTH          = 80,
    parameter int                ADDR_W         = 7,
    parameter int                DATA_W         = 8,
    parameter logic [DATA_W-1:0] FILL_CHAR      = 8'h20,
    parameter int                HOLDOFF_CYCLES = 2500,
    parameter int                BUSY_TIMEOUT   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              refresh_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              lcd_trg,
    input  logic              lcd_busy,
    output logic              dirty,
    output logic [15:0]       refresh_count,
    output logic              err_timeout
);

    localparam int TMR_W = 16;
    localparam logic [TMR_W-1:0]  BUSY_LOAD = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]  HOLD_LOAD = (HOLDOFF_CYCLES == 0) ? '0 : TMR_W'(HOLDOFF_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_HOLDOFF
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic                dirty_q, dirty_d;
    logic                clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [15:0]         refresh_count_q, refresh_count_d;
    logic                err_timeout_q, err_timeout_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic wr_fire;
    logic wr_in_range;
    logic rd_in_range;
    logic clr_last;
    logic trig_fire;

    assign wr_fire     = wr_valid && !clr_busy_q;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign clr_last    = clr_busy_q && (clr_addr_q == CLR_LAST);

    assign wr_ready      = !clr_busy_q;
    assign clr_busy      = clr_busy_q;
    assign rd_data       = rd_in_range ? mem_q[rd_addr] : FILL_CHAR;
    assign lcd_trg       = (state_q == S_TRIG);
    assign dirty         = dirty_q;
    assign refresh_count = refresh_count_q;
    assign err_timeout   = err_timeout_q;

    // Host writes and the clear sweep never collide: wr_ready is low while sweeping.
    always_comb begin
        mem_d      = mem_q;
        clr_busy_d = clr_busy_q;
        clr_addr_d = clr_addr_q;
        if (wr_fire && wr_in_range) begin
            mem_d[wr_addr] = wr_data;
        end
        if (clr_busy_q) begin
            mem_d[clr_addr_q] = FILL_CHAR;
            if (clr_last) begin
                clr_busy_d = 1'b0;
            end else begin
                clr_addr_d = clr_addr_q + ADDR_W'(1);
            end
        end else if (clr_req) begin
            clr_busy_d = 1'b1;
            clr_addr_d = '0;
        end
    end

    always_comb begin
        state_d         = state_q;
        tmr_d           = tmr_q;
        refresh_count_d = refresh_count_q;
        err_timeout_d   = err_timeout_q;
        trig_fire       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dirty_q && !lcd_busy) begin
                    state_d   = S_TRIG;
                    trig_fire = 1'b1;
                end
            end
            S_TRIG: begin
                state_d = S_WAIT_BUSY;
                tmr_d   = BUSY_LOAD;
            end
            S_WAIT_BUSY: begin
                if (lcd_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (tmr_q == '0) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_HOLDOFF;
                    tmr_d         = HOLD_LOAD;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (refresh_count_q != 16'hFFFF) begin
                        refresh_count_d = refresh_count_q + 16'd1;
                    end
                    state_d = S_HOLDOFF;
                    tmr_d   = HOLD_LOAD;
                end
            end
            S_HOLDOFF: begin
                if (tmr_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new change in the same cycle as the trigger must not be lost.
        dirty_d = dirty_q;
        if (trig_fire) begin
            dirty_d = 1'b0;
        end
        if ((wr_fire && wr_in_range) || clr_last || refresh_req) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            tmr_q           <= '0;
            dirty_q         <= 1'b0;
            clr_busy_q      <= 1'b0;
            clr_addr_q      <= '0;
            refresh_count_q <= '0;
            err_timeout_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= FILL_CHAR;
            end
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            dirty_q         <= dirty_d;
            clr_busy_q      <= clr_busy_d;
            clr_addr_q      <= clr_addr_d;
            refresh_count_q <= refresh_count_d;
            err_timeout_q   <= err_timeout_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_lcd_refresh_scheduler.sv
// Bench for lcd_refresh_scheduler: a timestamp-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_lcd_refresh_scheduler;

    localparam int         DEPTH = 80;
    localparam int         HOLD  = 2500;
    localparam int         BT    = 8;
    localparam logic [7:0] FILL  = 8'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [6:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        refresh_req = 1'b0;
    logic [6:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic        lcd_trg;
    logic        lcd_busy = 1'b1;
    logic        dirty;
    logic [15:0] refresh_count;
    logic        err_timeout;

    always #5 clk = ~clk;

    lcd_refresh_scheduler dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_req(clr_req), .clr_busy(clr_busy), .refresh_req(refresh_req),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .lcd_trg(lcd_trg), .lcd_busy(lcd_busy), .dirty(dirty),
        .refresh_count(refresh_count), .err_timeout(err_timeout)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: frame contents, sweep countdown, and print timing kept as
    // edge timestamps (trigger edge, edge from which a new trigger may be issued).
    logic [7:0]  m_mem [DEPTH];
    int          m_clr_left, m_edge, m_trg_edge, m_free_at;
    bit          m_dirty, m_err, m_awaiting, m_printing, m_trg, m_set;
    int unsigned m_count;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
        m_clr_left = 0; m_edge = 0; m_trg_edge = -10; m_free_at = 0;
        m_dirty = 0; m_err = 0; m_awaiting = 0; m_printing = 0; m_trg = 0;
        m_count = 0;
    endtask

    task automatic model_step();
        int hold;
        hold  = (HOLD == 0) ? 1 : HOLD;
        m_set = 0;
        m_edge++;
        if (wr_valid && m_clr_left == 0 && int'(wr_addr) < DEPTH) begin
            m_mem[wr_addr] = wr_data;
            m_set = 1;
        end
        if (m_clr_left > 0) begin
            m_mem[DEPTH - m_clr_left] = FILL;
            m_clr_left--;
            if (m_clr_left == 0) m_set = 1;
        end else if (clr_req) begin
            m_clr_left = DEPTH;
        end
        if (refresh_req) m_set = 1;

        if (m_awaiting) begin
            if (m_edge >= m_trg_edge + 2) begin
                if (lcd_busy) begin
                    m_awaiting = 0;
                    m_printing = 1;
                end else if (m_edge == m_trg_edge + 1 + BT) begin
                    m_awaiting = 0;
                    m_err = 1;
                    m_free_at = m_edge + hold + 1;
                end
            end
        end else if (m_printing) begin
            if (!lcd_busy) begin
                m_printing = 0;
                if (m_count < 65535) m_count++;
                m_free_at = m_edge + hold + 1;
            end
        end else if (m_edge >= m_free_at && m_dirty && !lcd_busy) begin
            m_trg_edge = m_edge;
            m_awaiting = 1;
            m_dirty = 0;
        end
        if (m_set) m_dirty = 1;
        m_trg = m_awaiting && (m_edge == m_trg_edge);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(posedge clk);
        #3;
        if (rst) begin
            chk("m_trg", lcd_trg, m_trg);
            chk("m_dirty", dirty, m_dirty);
            chk("m_clr_busy", clr_busy, m_clr_left != 0);
            chk("m_wr_ready", wr_ready, m_clr_left == 0);
            chk("m_count", refresh_count, m_count);
            chk("m_err", err_timeout, m_err);
            chk("m_rd_data", rd_data, (int'(rd_addr) < DEPTH) ? m_mem[rd_addr] : FILL);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_trg(input string name, input int max, output int t);
        t = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (lcd_trg) begin
                t = cyc;
                break;
            end
        end
        chk({"trg_seen_", name}, t >= 0, 1);
    endtask

    // Called at the negedge where lcd_trg was first seen; returns the edge at
    // which the scheduler first samples lcd_busy low.
    task automatic serve(input int len, output int f);
        lcd_busy = 1'b1;
        tick(len);
        lcd_busy = 1'b0;
        f = cyc + 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_trg"}, lcd_trg, 0);
        chk({tag, "_dirty"}, dirty, 0);
        chk({tag, "_clr_busy"}, clr_busy, 0);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_count"}, refresh_count, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    int t, t2, f, c, n, first_ready, e;

    initial begin
        #2;
        check_reset_outputs("rst0");
        @(negedge clk);
        rst = 1'b1;

        // Boot: driver busy for 1000 cycles; a refresh request must wait for it.
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            rd_addr = 7'(i % 128);
            refresh_req = (i == 100);
            @(negedge clk);
            chk("boot_rd", rd_data, FILL);
            if (i == 50) chk("boot_dirty0", dirty, 0);
            if (i == 200) chk("boot_dirty1", dirty, 1);
            if (lcd_trg) n++;
        end
        chk("boot_no_trg", n, 0);
        lcd_busy = 1'b0;
        c = cyc;
        wait_trg("boot", 10, t);
        chk("boot_trg_lat", t, c + 1);
        serve(10, f);
        tick(3);
        chk("boot_count", refresh_count, 1);
        tick(HOLD + 10);

        // Write and print, with a write landing mid-print.
        wr_valid = 1'b1; wr_addr = 7'd21; wr_data = 8'h41; rd_addr = 7'd21;
        c = cyc;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wp_rd21", rd_data, 8'h41);
        chk("wp_dirty", dirty, 1);
        chk("wp_trg_early", lcd_trg, 0);
        wait_trg("wp", 5, t);
        chk("wp_trg_lat", t, c + 2);
        @(negedge clk);
        chk("wp_trg_width", lcd_trg, 0);
        lcd_busy = 1'b1;
        tick(50);
        wr_valid = 1'b1; wr_addr = 7'd0; wr_data = 8'h30;
        tick(1);
        wr_valid = 1'b0;
        chk("wdp_dirty", dirty, 1);
        tick(148);
        lcd_busy = 1'b0;
        f = cyc + 1;
        tick(2);
        chk("wp_count", refresh_count, 2);
        wait_trg("second", HOLD + 20, t2);
        chk("second_trg_gap", t2 - f, HOLD + 1);
        serve(5, f);
        tick(HOLD + 10);

        // Fill with 0x55 then clear; the driver is held busy so no print starts.
        lcd_busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_addr = 7'(i); wr_data = 8'h55;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rd_addr = 7'd79;
        @(negedge clk);
        chk("fill_rd79", rd_data, 8'h55);
        clr_req = 1'b1;
        c = cyc;
        @(negedge clk);
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_addr = 7'd3; wr_data = 8'h77;
        n = 0;
        first_ready = -1;
        for (int i = 0; i < 200; i++) begin
            clr_req = (i == 40);
            if (clr_busy) n++;
            if (wr_ready) begin
                first_ready = cyc;
                break;
            end
            @(negedge clk);
        end
        clr_req = 1'b0;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("clr_busy_len", n, DEPTH);
        chk("clr_ready_at", first_ready - c, DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = 7'(i);
            @(negedge clk);
            chk("clr_rd", rd_data, (i == 3) ? 8'h77 : 8'h20);
        end
        chk("clr_dirty", dirty, 1);
        lcd_busy = 1'b0;
        wait_trg("clr_print", 5, t);
        serve(5, f);
        tick(5);
        chk("clr_count", refresh_count, 4);
        chk("post_print_dirty", dirty, 0);

        // Out-of-range write is acknowledged and dropped.
        wr_valid = 1'b1; wr_addr = 7'd85; wr_data = 8'h99; rd_addr = 7'd85;
        @(negedge clk);
        wr_valid = 1'b0;
        chk("oor_dirty", dirty, 0);
        chk("oor_rd85", rd_data, 8'h20);
        rd_addr = 7'd5;
        @(negedge clk);
        chk("oor_rd5", rd_data, 8'h20);
        tick(HOLD + 10);

        // Timeout: trigger with the driver never answering.
        refresh_req = 1'b1;
        @(negedge clk);
        refresh_req = 1'b0;
        wait_trg("to", 5, t);
        e = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (err_timeout) begin
                e = cyc;
                break;
            end
        end
        chk("to_lat", e - t, BT + 1);
        chk("to_count", refresh_count, 4);

        // Async reset while in holdoff and mid-clear.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        tick(20);
        chk("pre_rst_clr_busy", clr_busy, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < DEPTH; i += 7) begin
            rd_addr = 7'(i);
            @(negedge clk);
            chk("rst_rd", rd_data, FILL);
        end
        rst = 1'b1;
        tick(5);
        check_reset_outputs("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
